navigate: RTL

- Motion executor directly downstream of the maze solver.
- Accepts the solver's one-cycle `strt_hdng` / `strt_mv` commands plus its `stp_lft` / `stp_rght` wall-following preference.
- Drives the forward-speed setpoint to the PID/motor stage.
- Returns a one-cycle `mv_cmplt` when a heading change or a forward move has finished, which advances the solver FSM.

---
 rtl/nav_pkg.sv | 27 ++
 rtl/navigate_if.sv | 32 +++
 rtl/nav_spd_ramp.sv | 68 ++++++
 rtl/navigate.sv | 138 +++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// Shared types and constants for the navigate motion executor.
// Holds the state encoding, the default speed limits and the ramp-step selector.
package nav_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDNG     = 3'd1,
    MOVE     = 3'd2,
    DEC_NORM = 3'd3,
    DEC_FAST = 3'd4
  } nav_state_t;

  localparam logic [10:0] MAX_FRWRD_DEF = 11'h2A0;
  localparam logic [10:0] MIN_FRWRD_DEF = 11'h0D0;

  // Short simulations use a coarse step so a full ramp takes tens of ticks.
  function automatic logic [10:0] frwrd_inc(input logic fast_sim);
    logic [10:0] step;
    if (fast_sim) begin
      step = 11'h018;
    end else begin
      step = 11'h002;
    end
    return step;
  endfunction

endpackage

// File: rtl/navigate_if.sv
// Command/status bundle between the maze solver, the sensors and navigate.
// The master side issues commands and sensor flags; the slave side is navigate.
interface navigate_if;
  import nav_pkg::*;

  logic        strt_hdng;
  logic        strt_mv;
  logic        stp_lft;
  logic        stp_rght;
  logic        hdng_rdy;
  logic        at_hdng;
  logic        lft_opn;
  logic        rght_opn;
  logic        frwrd_opn;
  logic        mv_cmplt;
  logic        moving;
  logic        en_fusion;
  logic [10:0] frwrd_spd;

  modport master (
    output strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy,
           at_hdng, lft_opn, rght_opn, frwrd_opn,
    input  mv_cmplt, moving, en_fusion, frwrd_spd
  );

  modport slave (
    input  strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy,
           at_hdng, lft_opn, rght_opn, frwrd_opn,
    output mv_cmplt, moving, en_fusion, frwrd_spd
  );

endinterface

// File: rtl/nav_spd_ramp.sv
// Forward-speed setpoint register: loads the start speed, clears, and on each
// heading tick ramps up to the ceiling or down to zero without wrapping.
module nav_spd_ramp
  import nav_pkg::*;
#(
  parameter bit          FAST_SIM  = 1'b1,
  parameter logic [10:0] MAX_FRWRD = MAX_FRWRD_DEF,
  parameter logic [10:0] MIN_FRWRD = MIN_FRWRD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_min,
  input  logic        clr,
  input  logic        inc,
  input  logic        dec_norm,
  input  logic        dec_fast,
  input  logic        hdng_rdy,
  output logic [10:0] frwrd_spd
);

  localparam logic [10:0] INC_STEP  = frwrd_inc(FAST_SIM);
  localparam logic [10:0] NORM_STEP = INC_STEP << 1;
  localparam logic [10:0] FAST_STEP = INC_STEP << 2;

  function automatic logic [10:0] sat_sub(input logic [10:0] spd, input logic [10:0] step);
    logic [10:0] res;
    if (spd > step) begin
      res = spd - step;
    end else begin
      res = 11'd0;
    end
    return res;
  endfunction

  logic [11:0] sum_s;
  logic [10:0] spd_r;

  // Twelve-bit sum so the ceiling compare can never see a wrapped value.
  always_comb begin
    sum_s = {1'b0, spd_r} + {1'b0, INC_STEP};
  end

  // Speed register; a move start outranks a clear so IDLE can load directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      spd_r <= 11'd0;
    end else if (load_min) begin
      spd_r <= MIN_FRWRD;
    end else if (clr) begin
      spd_r <= 11'd0;
    end else if (hdng_rdy) begin
      if (dec_fast) begin
        spd_r <= sat_sub(spd_r, FAST_STEP);
      end else if (dec_norm) begin
        spd_r <= sat_sub(spd_r, NORM_STEP);
      end else if (inc) begin
        spd_r <= (sum_s > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : sum_s[10:0];
      end else begin
        spd_r <= spd_r;
      end
    end else begin
      spd_r <= spd_r;
    end
  end

  assign frwrd_spd = spd_r;

endmodule

// File: rtl/navigate.sv
// Motion executor below the maze solver: runs heading changes and forward
// moves, ramps the speed setpoint and reports completion with a one-cycle pulse.
module navigate
  import nav_pkg::*;
#(
  parameter bit          FAST_SIM  = 1'b1,
  parameter logic [10:0] MAX_FRWRD = MAX_FRWRD_DEF,
  parameter logic [10:0] MIN_FRWRD = MIN_FRWRD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  navigate_if.slave  nav
);

  nav_state_t  state_r;
  nav_state_t  state_nxt_s;
  logic        mv_cmplt_r;
  logic        mv_cmplt_nxt_s;
  logic        lft_prev_r;
  logic        rght_prev_r;
  logic        lft_rise_s;
  logic        rght_rise_s;
  logic        load_min_s;
  logic        clr_s;
  logic        inc_s;
  logic        dec_norm_s;
  logic        dec_fast_s;
  logic        moving_s;
  logic [10:0] spd_s;

  nav_spd_ramp #(
    .FAST_SIM  (FAST_SIM),
    .MAX_FRWRD (MAX_FRWRD),
    .MIN_FRWRD (MIN_FRWRD)
  ) u_ramp (
    .clk       (clk),
    .rst       (rst),
    .load_min  (load_min_s),
    .clr       (clr_s),
    .inc       (inc_s),
    .dec_norm  (dec_norm_s),
    .dec_fast  (dec_fast_s),
    .hdng_rdy  (nav.hdng_rdy),
    .frwrd_spd (spd_s)
  );

  // Opening edge detectors and the registered completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_prev_r  <= 1'b0;
      rght_prev_r <= 1'b0;
      mv_cmplt_r  <= 1'b0;
      state_r     <= IDLE;
    end else begin
      lft_prev_r  <= nav.lft_opn;
      rght_prev_r <= nav.rght_opn;
      mv_cmplt_r  <= mv_cmplt_nxt_s;
      state_r     <= state_nxt_s;
    end
  end

  assign lft_rise_s  = nav.lft_opn & ~lft_prev_r;
  assign rght_rise_s = nav.rght_opn & ~rght_prev_r;

  // Next-state and ramp controls; a wall ahead always beats an opening stop.
  always_comb begin
    state_nxt_s    = state_r;
    mv_cmplt_nxt_s = 1'b0;
    load_min_s     = 1'b0;
    clr_s          = 1'b0;
    inc_s          = 1'b0;
    dec_norm_s     = 1'b0;
    dec_fast_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (nav.strt_hdng) begin
          state_nxt_s = HDNG;
          clr_s       = 1'b1;
        end else if (nav.strt_mv) begin
          state_nxt_s = MOVE;
          load_min_s  = 1'b1;
        end else begin
          clr_s       = 1'b1;
        end
      end
      HDNG: begin
        clr_s = 1'b1;
        if (nav.at_hdng) begin
          state_nxt_s    = IDLE;
          mv_cmplt_nxt_s = 1'b1;
        end else begin
          state_nxt_s    = HDNG;
        end
      end
      MOVE: begin
        inc_s = 1'b1;
        if (!nav.frwrd_opn) begin
          state_nxt_s = DEC_FAST;
        end else if ((nav.stp_lft & lft_rise_s) | (nav.stp_rght & rght_rise_s)) begin
          state_nxt_s = DEC_NORM;
        end else begin
          state_nxt_s = MOVE;
        end
      end
      DEC_NORM: begin
        dec_norm_s = 1'b1;
        if (spd_s == 11'd0) begin
          state_nxt_s    = IDLE;
          mv_cmplt_nxt_s = 1'b1;
        end else if (!nav.frwrd_opn) begin
          state_nxt_s    = DEC_FAST;
        end else begin
          state_nxt_s    = DEC_NORM;
        end
      end
      DEC_FAST: begin
        dec_fast_s = 1'b1;
        if (spd_s == 11'd0) begin
          state_nxt_s    = IDLE;
          mv_cmplt_nxt_s = 1'b1;
        end else begin
          state_nxt_s    = DEC_FAST;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        clr_s       = 1'b1;
      end
    endcase
  end

  assign moving_s      = (state_r != IDLE);
  assign nav.moving    = moving_s;
  assign nav.en_fusion = moving_s & (spd_s > (MAX_FRWRD >> 1));
  assign nav.mv_cmplt  = mv_cmplt_r;
  assign nav.frwrd_spd = spd_s;

endmodule
